// File: rtl/pe_array_collector.sv
// De-skews the bottom-row column sums of the PE array into aligned vectors and queues them for the RK update stage.
// Vector valid BASE_LAT+N cycles after launch; consumer backpressure is absorbed by launch credits, never by stalling.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic          head_vld,
  output logic [CW-1:0] occ
);
  logic [W-1:0]  entries [DEPTH];
  logic [CW-1:0] wr_cnt;
  logic [AW-1:0] wr_idx;

  // Entry 0 is always the head; a pop shifts everything down, so a concurrent
  // push lands one slot lower than it would without the pop.
  assign wr_cnt   = occ - CW'(pop);
  assign wr_idx   = AW'(wr_cnt);
  assign head_dat = entries[0];
  assign head_vld = (occ != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      occ <= '0;
    end else begin
      if (pop) begin
        for (int i = 0; i < DEPTH - 1; i++) entries[i] <= entries[i+1];
      end
      if (push) entries[wr_idx] <= push_dat;
      occ <= occ + CW'(push) - CW'(pop);
    end
  end
endmodule

module pe_array_collector #(
  parameter int WIDTH      = 32,
  parameter int N          = 3,
  parameter int S          = 3,
  parameter int BASE_LAT   = 3,
  parameter int FIFO_DEPTH = 2,
  localparam int SUM_W     = 2 * WIDTH + $clog2(S)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_launch,
  output logic               o_launch_ready,
  input  logic [N*SUM_W-1:0] i_col_sum,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [N*SUM_W-1:0] o_data,
  output logic               o_err
);
  localparam int PIPE_LEN = BASE_LAT + N - 1;
  localparam int CRED_W   = $clog2(PIPE_LEN + FIFO_DEPTH + 1);
  localparam int OCC_W    = $clog2(FIFO_DEPTH + 1);

  logic [PIPE_LEN-1:0] tok;
  logic                launch_ok;
  logic [CRED_W-1:0]   in_flight;
  logic [OCC_W-1:0]    occ;
  logic [N*SUM_W-1:0]  wr_dat;
  logic                pop;

  assign launch_ok = i_launch & o_launch_ready;
  assign pop       = o_valid & i_ready;

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < PIPE_LEN; i++) in_flight = in_flight + CRED_W'(tok[i]);
  end

  // Every token in the pipe already owns a FIFO slot, so a push can never find the FIFO full.
  assign o_launch_ready = (in_flight + CRED_W'(occ)) < CRED_W'(FIFO_DEPTH);

  always_ff @(posedge clk) begin
    if (rst) tok <= '0;
    else     tok <= (tok << 1) | PIPE_LEN'(launch_ok);
  end

  always_ff @(posedge clk) begin
    if (rst)                               o_err <= 1'b0;
    else if (i_launch && !o_launch_ready)  o_err <= 1'b1;
  end

  // Column j arrives j cycles after column 0, so it needs N-1-j stages to line up with column N-1.
  for (genvar j = 0; j < N; j++) begin : g_col
    if (j == N - 1) begin : g_last
      assign wr_dat[j*SUM_W +: SUM_W] = i_col_sum[j*SUM_W +: SUM_W];
    end else begin : g_dly
      localparam int D = N - 1 - j;
      logic [SUM_W-1:0] dly [D];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < D; k++) dly[k] <= '0;
        end else begin
          dly[0] <= i_col_sum[j*SUM_W +: SUM_W];
          for (int k = 1; k < D; k++) dly[k] <= dly[k-1];
        end
      end
      assign wr_dat[j*SUM_W +: SUM_W] = dly[D-1];
    end
  end

  sync_fifo #(
    .W     (N * SUM_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (tok[PIPE_LEN-1]),
    .push_dat (wr_dat),
    .pop      (pop),
    .head_dat (o_data),
    .head_vld (o_valid),
    .occ      (occ)
  );
endmodule
